fp_issue_collect: RTL and testbench

FP_ISSUE_COLLECT -- requirements
Module: fp_issue_collect

---
 rtl/fp_issue_collect.sv | 138 +++++++++++++
 tb/tb_fp_issue_collect.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_issue_collect.sv
// fp_issue_collect: issues operand requests to a fixed-latency FP unit and
// collects the returned results in a show-ahead FIFO. An issue-credit counter
// guarantees every in-flight result has a buffer slot. After reset, a DRAIN
// phase lets an unreset unit pipeline flush its stale returns.
// Optional feature macro: FP_ISSUE_COLLECT_OVF_CHECK_EN (sticky overflow flag,
// writes into a full buffer without a simultaneous pop are dropped).
module fp_issue_collect #(
  parameter int DEPTH     = 16,
  parameter int TAG_WIDTH = 4,
  parameter int LATENCY   = 14
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_opa,
  input  logic [31:0]          req_opb,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic [TAG_WIDTH:0]   go_out,
  output logic [31:0]          opa_out,
  output logic [31:0]          opb_out,
  input  logic [TAG_WIDTH:0]   done_in,
  input  logic [31:0]          result_in,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [TAG_WIDTH-1:0] rsp_tag,
  output logic                 err_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(LATENCY);
  localparam logic [AW:0]   CREDIT_MAX = (AW+1)'(DEPTH);

  typedef enum logic {DRAIN, RUN} state_t;

  state_t               state_q;
  logic [CW-1:0]        drain_q;
  logic [AW:0]          credit_q, credit_d;
  logic [AW:0]          wr_q, rd_q;
  logic [TAG_WIDTH:0]   go_q;
  logic [31:0]          opa_q, opb_q;
  logic [31:0]          data_mem [DEPTH];
  logic [TAG_WIDTH-1:0] tag_mem  [DEPTH];

  logic accept, pop, empty, wr_req, wr_en;

  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign empty     = (wr_q == rd_q);
  assign req_ready = (credit_q != '0) && (state_q == RUN);
  assign rsp_valid = !empty;
  assign rsp_data  = data_mem[rd_q[AW-1:0]];
  assign rsp_tag   = tag_mem[rd_q[AW-1:0]];
  assign go_out    = go_q;
  assign opa_out   = opa_q;
  assign opb_out   = opb_q;

  // Returns are only trusted once the stale unit pipeline has drained.
  assign wr_req = done_in[0] && (state_q == RUN);

`ifdef FP_ISSUE_COLLECT_OVF_CHECK_EN
  logic full, err_q;
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign wr_en   = wr_req && !(full && !pop);
  assign err_ovf = err_q;

  // Sticky overflow: a return that found no free slot was dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                    err_q <= 1'b0;
    else if (wr_req && full && !pop) err_q <= 1'b1;
  end
`else
  assign wr_en   = wr_req;
  assign err_ovf = 1'b0;
`endif

  // DRAIN waits LATENCY+1 cycles for in-flight returns to flush, then RUN forever.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DRAIN;
      drain_q <= '0;
    end else begin
      case (state_q)
        DRAIN: begin
          if (drain_q == DRAIN_LAST) state_q <= RUN;
          else                       drain_q <= drain_q + 1'b1;
        end
        RUN: state_q <= RUN;
      endcase
    end
  end

  // Credits: one consumed per issue, one returned per response pop.
  always_comb begin
    credit_d = credit_q;
    if (accept && !pop)      credit_d = credit_q - 1'b1;
    else if (pop && !accept) credit_d = credit_q + 1'b1;
  end

  // Credit and FIFO pointer registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      credit_q <= CREDIT_MAX;
      wr_q     <= '0;
      rd_q     <= '0;
    end else begin
      credit_q <= credit_d;
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
    end
  end

  // Issue register: go pulses for one cycle, operands hold their last value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      go_q  <= '0;
      opa_q <= '0;
      opb_q <= '0;
    end else begin
      go_q <= accept ? {req_tag, 1'b1} : '0;
      if (accept) begin
        opa_q <= req_opa;
        opb_q <= req_opb;
      end
    end
  end

  // Result storage; contents are meaningless outside the pointer window.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      data_mem[wr_q[AW-1:0]] <= result_in;
      tag_mem[wr_q[AW-1:0]]  <= done_in[TAG_WIDTH:1];
    end
  end

endmodule

// File: tb/tb_fp_issue_collect.sv
// Bench for fp_issue_collect: a default instance (DEPTH 16) and a DEPTH 4
// instance, each attached to a fixed-latency unit model returning opa+opb.
module tb_fp_issue_collect;

  localparam int LAT = 14;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // DEPTH 16 instance signals
  logic        req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, err_ovf;
  logic [31:0] req_opa = 0, req_opb = 0, opa_out, opb_out, result_in, rsp_data;
  logic [3:0]  req_tag = 0, rsp_tag;
  logic [4:0]  go_out, done_in;

  // DEPTH 4 instance signals
  logic        d4_valid = 0, d4_ready, d4_rsp_valid, d4_rsp_ready = 0, d4_err;
  logic [31:0] d4_opa_out, d4_opb_out, d4_result, d4_rsp_data;
  logic [3:0]  d4_tag = 0, d4_rsp_tag;
  logic [4:0]  d4_go, d4_done;
  logic        frc = 0;
  logic [4:0]  frc_done = 0;

  fp_issue_collect dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opa(req_opa),
    .req_opb(req_opb), .req_tag(req_tag),
    .go_out(go_out), .opa_out(opa_out), .opb_out(opb_out),
    .done_in(done_in), .result_in(result_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .err_ovf(err_ovf));

  fp_issue_collect #(.DEPTH(4), .TAG_WIDTH(4), .LATENCY(LAT)) dut4 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(d4_valid), .req_ready(d4_ready), .req_opa(32'd0),
    .req_opb(32'd0), .req_tag(d4_tag),
    .go_out(d4_go), .opa_out(d4_opa_out), .opb_out(d4_opb_out),
    .done_in(d4_done), .result_in(d4_result),
    .rsp_valid(d4_rsp_valid), .rsp_ready(d4_rsp_ready), .rsp_data(d4_rsp_data),
    .rsp_tag(d4_rsp_tag), .err_ovf(d4_err));

  // Unit models: never reset, so in-flight work survives a DUT reset.
  logic [4:0]  pg  [LAT] = '{default: '0};
  logic [31:0] pr  [LAT] = '{default: '0};
  logic [4:0]  pg4 [LAT] = '{default: '0};
  logic [31:0] pr4 [LAT] = '{default: '0};

  always @(posedge clock) begin
    pg[0]  <= go_out;  pr[0]  <= opa_out + opb_out;
    pg4[0] <= d4_go;   pr4[0] <= d4_opa_out + d4_opb_out;
    for (int i = 1; i < LAT; i++) begin
      pg[i]  <= pg[i-1];  pr[i]  <= pr[i-1];
      pg4[i] <= pg4[i-1]; pr4[i] <= pr4[i-1];
    end
  end

  assign done_in   = pg[LAT-1];
  assign result_in = pr[LAT-1];
  assign d4_done   = frc ? frc_done : pg4[LAT-1];
  assign d4_result = frc ? 32'h0000_00F0 : pr4[LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [4:0]  exp_go;
    logic [31:0] exp_res;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    tbl[0] = '{4'd3,  32'h0000_0001, 32'h0000_0002, 5'h07, 32'h0000_0003};
    tbl[1] = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 5'h01, 32'h0000_0000};
    tbl[2] = '{4'd15, 32'h1234_5678, 32'h1111_1111, 5'h1F, 32'h2345_6789};
    tbl[3] = '{4'd10, 32'h8000_0000, 32'h7FFF_FFFF, 5'h15, 32'hFFFF_FFFF};
    tbl[4] = '{4'd5,  32'hDEAD_0000, 32'h0000_BEEF, 5'h0B, 32'hDEAD_BEEF};

    // Reset state
    ticks(2);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_go_out", go_out, 0);
    chk("rst_err_ovf", err_ovf, 0);
    chk("rst_opa_opb", {opa_out, opb_out}, 0);
    chk("rst_credits", dut.credit_q, 16);
    reset_n = 1'b1;
    k = 0;
    while (!req_ready && k < 40) begin tick(); k++; end
    chk("drain_cycles", k, 15);

    // Single ops from the vector table
    rsp_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      req_valid = 1'b1; req_tag = tbl[v].tag; req_opa = tbl[v].opa; req_opb = tbl[v].opb;
      chk("vec_ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      chk("vec_go", go_out, tbl[v].exp_go);
      chk("vec_ops", {opa_out, opb_out}, {tbl[v].opa, tbl[v].opb});
      k = 0;
      tick(); k++;
      chk("vec_go_pulse", go_out, 0);
      chk("vec_ops_hold", {opa_out, opb_out}, {tbl[v].opa, tbl[v].opb});
      while (!rsp_valid && k < 40) begin tick(); k++; end
      chk("vec_latency", k, 15);
      chk("vec_rsp", {28'd0, rsp_tag, rsp_data}, {28'd0, tbl[v].tag, tbl[v].exp_res});
      tick();
      chk("vec_popped", rsp_valid, 0);
      chk("vec_credits", dut.credit_q, 16);
    end

    // Back-to-back 16 ops, responses must stream without gaps
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_tag = 4'(i); req_opa = i; req_opb = 32'h100;
      chk("b2b_ready", req_ready, 1);
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("b2b_rsp", {rsp_valid, 4'd0, rsp_tag, rsp_data},
          {1'b1, 4'd0, 4'(i), 32'(i) + 32'h100});
      tick();
    end
    chk("b2b_empty", rsp_valid, 0);
    chk("b2b_credits", dut.credit_q, 16);

    // Reset with 5 ops in flight; stale returns must be ignored during DRAIN
    for (int i = 1; i <= 5; i++) begin
      req_valid = 1'b1; req_tag = 4'(i); req_opa = i; req_opb = 0;
      tick();
    end
    req_valid = 1'b0;
    ticks(3);
    reset_n = 1'b0;
    #1;
    chk("midrst_outputs", {req_ready, rsp_valid, go_out}, 0);
    tick();
    reset_n = 1'b1;
    k = 0;
    while (!req_ready && k < 40) begin
      tick(); k++;
      chk("midrst_no_rsp", rsp_valid, 0);
    end
    chk("midrst_drain", k, 15);
    ticks(3);
    chk("midrst_still_empty", rsp_valid, 0);
    rsp_ready = 1'b0;

    // DEPTH 4: credit exhaustion
    d4_rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      d4_valid = 1'b1; d4_tag = 4'(i);
      chk("d4_ready", d4_ready, 1);
      tick();
    end
    d4_valid = 1'b0;
    chk("d4_exhausted", {d4_ready, 3'd0, dut4.credit_q}, 0);
    ticks(20);
    chk("d4_head", {d4_rsp_valid, d4_rsp_tag}, {1'b1, 4'd1});

    // Pop with zero credits and a pending request: no accept on that edge
    d4_valid = 1'b1; d4_tag = 4'd5; d4_rsp_ready = 1'b1;
    tick();
    chk("d4_zero_no_accept", d4_go, 0);
    chk("d4_zero_credits", dut4.credit_q, 1);
    chk("d4_zero_ready", d4_ready, 1);
    chk("d4_zero_head", d4_rsp_tag, 2);
    d4_rsp_ready = 1'b0;
    tick();
    chk("d4_fifth_go", d4_go, 5'h0B);
    chk("d4_fifth_credits", dut4.credit_q, 0);
    d4_valid = 1'b0;

    // Accept and pop together with one credit: credits unchanged
    d4_rsp_ready = 1'b1;
    tick();
    d4_rsp_ready = 1'b0;
    chk("d4_one_credit", dut4.credit_q, 1);
    d4_valid = 1'b1; d4_tag = 4'd6; d4_rsp_ready = 1'b1;
    tick();
    d4_valid = 1'b0; d4_rsp_ready = 1'b0;
    chk("d4_both_go", d4_go, 5'h0D);
    chk("d4_both_credits", dut4.credit_q, 1);
    chk("d4_both_head", d4_rsp_tag, 4);

    // Fill the buffer: [4,5,6,7]
    ticks(20);
    d4_valid = 1'b1; d4_tag = 4'd7;
    tick();
    d4_valid = 1'b0;
    ticks(20);
    chk("d4_full", {d4_ready, d4_rsp_valid, d4_rsp_tag}, {1'b0, 1'b1, 4'd4});

    // Write and pop on the same edge while full both take effect
    frc = 1'b1; frc_done = {4'd10, 1'b1}; d4_rsp_ready = 1'b1;
    tick();
    frc = 1'b0;
    chk("d4_fullpop_head", d4_rsp_tag, 5);
    chk("d4_fullpop_err", d4_err, 0);
    for (int i = 5; i <= 7; i++) begin
      chk("d4_drain_tag", d4_rsp_tag, 4'(i));
      tick();
    end
    d4_rsp_ready = 1'b0;
    chk("d4_fullpop_written", {d4_rsp_tag, d4_rsp_data}, {4'd10, 32'hF0});

    // Refill to full by direct returns, then one more without a pop
    for (int i = 11; i <= 14; i++) begin
      frc = 1'b1; frc_done = {4'(i), 1'b1};
      tick();
    end
    frc = 1'b0;
`ifdef FP_ISSUE_COLLECT_OVF_CHECK_EN
    chk("ovf_set", d4_err, 1);
    ticks(3);
    chk("ovf_sticky", d4_err, 1);
    chk("ovf_dropped_head", d4_rsp_tag, 10);
    d4_rsp_ready = 1'b1;
    for (int i = 10; i <= 13; i++) begin
      chk("ovf_order", {d4_rsp_valid, d4_rsp_tag}, {1'b1, 4'(i)});
      tick();
    end
    d4_rsp_ready = 1'b0;
    chk("ovf_empty", d4_rsp_valid, 0);
`else
    chk("ovf_tied_low", d4_err, 0);
    ticks(3);
    chk("ovf_tied_low_later", d4_err, 0);
`endif
    chk("main_err_low", err_ovf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
